// File: rtl/id_token_fsm.sv
// id_token_fsm
//   Recognises identifier tokens of the form LETTER+ DIGIT+ in a byte stream.
//   'out' is high while the consumed stream ends in such a token with at
//   least MIN_ALPHA letters and MIN_DIGIT digits.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   char       in   [7:0] ASCII character, consumed when char_vld=1
//   char_vld   in   1 = consume char this edge, 0 = hold all state
//   out        out  token-match flag (registered, Moore)
//   tok_len    out  [CNT_W:0] letters + digits of the current token
//   match_cnt  out  [MATCH_W-1:0] count of out rising transitions, wraps
//
// Configuration
//   ID_UNDERSCORE_EN  when defined, 8'h5F ('_') is treated as a letter;
//                     otherwise it is a separator.
module id_token_fsm #(
    parameter int MIN_ALPHA = 1,
    parameter int MIN_DIGIT = 1,
    parameter int CNT_W     = 4,
    parameter int MATCH_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         char,
    input  logic               char_vld,
    output logic               out,
    output logic [CNT_W:0]     tok_len,
    output logic [MATCH_W-1:0] match_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALPHA = 2'd1,
        S_DIGIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   alpha_q, alpha_d;
    logic [CNT_W-1:0]   digit_q, digit_d;
    logic               out_q, out_d;
    logic [MATCH_W-1:0] match_q, match_d;

    logic is_alpha_letter;
    logic is_letter;
    logic is_digit;

    assign is_alpha_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                             ((char >= 8'h61) && (char <= 8'h7A));
`ifdef ID_UNDERSCORE_EN
    assign is_letter = is_alpha_letter || (char == 8'h5F);
`else
    assign is_letter = is_alpha_letter;
`endif
    assign is_digit = (char >= 8'h30) && (char <= 8'h39);

    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        digit_d = digit_q;
        if (char_vld) begin
            if (is_letter) begin
                state_d = S_ALPHA;
                if (state_q == S_ALPHA) begin
                    alpha_d = (alpha_q == '1) ? alpha_q : alpha_q + CNT_W'(1);
                end else begin
                    alpha_d = CNT_W'(1);
                    digit_d = '0;
                end
            end else if (is_digit) begin
                case (state_q)
                    S_ALPHA: begin
                        state_d = S_DIGIT;
                        digit_d = CNT_W'(1);
                    end
                    S_DIGIT: begin
                        digit_d = (digit_q == '1) ? digit_q : digit_q + CNT_W'(1);
                    end
                    default: begin
                        state_d = S_IDLE;
                        alpha_d = '0;
                        digit_d = '0;
                    end
                endcase
            end else begin
                state_d = S_IDLE;
                alpha_d = '0;
                digit_d = '0;
            end
        end
        // out is registered from the next state so it is a pure function of
        // the state registers one edge later, with no input-to-output path.
        out_d   = (state_d == S_DIGIT) &&
                  (alpha_d >= CNT_W'(MIN_ALPHA)) &&
                  (digit_d >= CNT_W'(MIN_DIGIT));
        match_d = (out_d && !out_q) ? match_q + MATCH_W'(1) : match_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            alpha_q <= '0;
            digit_q <= '0;
            out_q   <= 1'b0;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            alpha_q <= alpha_d;
            digit_q <= digit_d;
            out_q   <= out_d;
            match_q <= match_d;
        end
    end

    assign out       = out_q;
    assign tok_len   = {1'b0, alpha_q} + {1'b0, digit_q};
    assign match_cnt = match_q;

endmodule

// File: tb/tb_id_token_fsm.sv
// tb_id_token_fsm
//   Drives directed character streams into two instances (default minimums
//   and MIN_ALPHA=2/MIN_DIGIT=3) and compares them on every falling clock
//   edge against a model that re-scans the consumed character history.
module tb_id_token_fsm;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic       clk;
    logic       rst_n;
    logic [7:0] ch;
    logic       ch_vld;

    logic         out0, out1;
    logic [4:0]   tok0, tok1;
    logic [7:0]   m0, m1;

    int nchk = 0;
    int nerr = 0;

    id_token_fsm #(.MIN_ALPHA(1), .MIN_DIGIT(1), .CNT_W(CNT_W), .MATCH_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .char(ch), .char_vld(ch_vld),
        .out(out0), .tok_len(tok0), .match_cnt(m0)
    );

    id_token_fsm #(.MIN_ALPHA(2), .MIN_DIGIT(3), .CNT_W(CNT_W), .MATCH_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .char(ch), .char_vld(ch_vld),
        .out(out1), .tok_len(tok1), .match_cnt(m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit m_letter(input byte c);
        bit r;
        r = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
`ifdef ID_UNDERSCORE_EN
        r = r || (c == 8'h5F);
`endif
        return r;
    endfunction

    function automatic bit m_digit(input byte c);
        return (c >= 8'h30 && c <= 8'h39);
    endfunction

    byte        hist[$];
    logic [7:0] mm0, mm1;
    bit         po0, po1;

    // Token = maximal letter run followed by maximal digit run at the end of
    // the history; digits with no letters before them form no token.
    task automatic model_eval(input int mina, input int mind, output bit o, output int tl);
        int i, d, l, a, dd;
        i = hist.size() - 1;
        d = 0;
        l = 0;
        while (i >= 0 && m_digit(hist[i])) begin d++; i--; end
        while (i >= 0 && m_letter(hist[i])) begin l++; i--; end
        if (d > 0 && l == 0) begin
            o  = 1'b0;
            tl = 0;
        end else begin
            a  = (l > SAT) ? SAT : l;
            dd = (d > SAT) ? SAT : d;
            tl = a + dd;
            o  = (d > 0) && (a >= mina) && (dd >= mind);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit o;
        int tl;
        if (!rst_n) begin
            hist.delete();
            mm0 = 8'd0;
            mm1 = 8'd0;
            po0 = 1'b0;
            po1 = 1'b0;
        end else if (ch_vld) begin
            hist.push_back(ch);
            if (hist.size() > 200) void'(hist.pop_front());
            model_eval(1, 1, o, tl);
            if (o && !po0) mm0 = mm0 + 8'd1;
            po0 = o;
            model_eval(2, 3, o, tl);
            if (o && !po1) mm1 = mm1 + 8'd1;
            po1 = o;
        end
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        bit o;
        int tl;
        model_eval(1, 1, o, tl);
        chk("out0", int'(out0), int'(o));
        chk("tok0", int'(tok0), tl);
        chk("match0", int'(m0), int'(mm0));
        model_eval(2, 3, o, tl);
        chk("out1", int'(out1), int'(o));
        chk("tok1", int'(tok1), tl);
        chk("match1", int'(m1), int'(mm1));
    end

    // ---------------- stimulus ----------------
    task automatic step(input byte c, input bit v);
        @(negedge clk);
        #1;
        ch     = c;
        ch_vld = v;
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ch     = 8'h20;
        ch_vld = 1'b0;
        #12;
        chk("rst_out", int'(out0), 0);
        chk("rst_tok", int'(tok0), 0);
        chk("rst_match", int'(m0), 0);
        rst_n = 1'b1;

        // "abcd1234 "
        feed("abcd");
        chk("abcd_out", int'(out0), 0);
        feed("1");
        chk("a1_out", int'(out0), 1);
        feed("234");
        chk("a4_out", int'(out0), 1);
        chk("a4_tok", int'(tok0), 8);
        chk("a4_match", int'(m0), 1);
        feed(" ");
        chk("sp_out", int'(out0), 0);
        chk("sp_match", int'(m0), 1);

        // MIN_ALPHA=2 MIN_DIGIT=3
        do_reset();
        feed("a123 ab12 ab12");
        chk("p_pre_out", int'(out1), 0);
        feed("3");
        chk("p_out", int'(out1), 1);
        chk("p_match", int'(m1), 1);

        // "a1b2"
        do_reset();
        feed("a1");
        chk("a1b2_1", int'(out0), 1);
        feed("b");
        chk("a1b2_b", int'(out0), 0);
        feed("2");
        chk("a1b2_2", int'(out0), 1);
        chk("a1b2_m", int'(m0), 2);
        chk("a1b2_t", int'(tok0), 2);

        // saturation
        do_reset();
        feed("x");
        for (int i = 0; i < 20; i++) step(8'h37, 1'b1);
        chk("sat_tok", int'(tok0), 16);
        chk("sat_out", int'(out0), 1);
        chk("sat_match", int'(m0), 1);

        // hold and async reset
        do_reset();
        feed("ab");
        for (int i = 0; i < 3; i++) begin
            step(8'h31, 1'b0);
            chk("hold_out", int'(out0), 0);
            chk("hold_tok", int'(tok0), 2);
        end
        step(8'h31, 1'b1);
        chk("rel_out", int'(out0), 1);
        chk("rel_match", int'(m0), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out", int'(out0), 0);
        chk("arst_tok", int'(tok0), 0);
        chk("arst_match", int'(m0), 0);
        rst_n = 1'b1;
        feed("2");
        chk("post_out", int'(out0), 0);
        chk("post_tok", int'(tok0), 0);
        feed("c5");
        chk("post_c5_out", int'(out0), 1);
        chk("post_c5_tok", int'(tok0), 2);

        // underscore
        do_reset();
        feed("_a1");
        chk("us_out", int'(out0), 1);
`ifdef ID_UNDERSCORE_EN
        chk("us_tok", int'(tok0), 3);
`else
        chk("us_tok", int'(tok0), 2);
`endif

        // match counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) feed("a1 ");
        chk("wrap0", int'(m0), 0);
        feed("a1");
        chk("wrap1", int'(m0), 1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/id_token_fsm.md
ID_TOKEN_FSM -- requirements
Module: id_token_fsm

Interface
REQ-001 Parameter MIN_ALPHA, default 1, minimum leading-letter count for a match (1..2^CNT_W-1).
REQ-002 Parameter MIN_DIGIT, default 1, minimum trailing-digit count for a match (1..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 4, width of the letter/digit run counters.
REQ-004 Parameter MATCH_W, default 8, width of the match event counter.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 char  input  8  ASCII character sampled on the rising edge.
REQ-008 char_vld  input  1  1 = char is consumed this edge; 0 = all state holds.
REQ-009 out  output  1  1 while the consumed stream ends in a valid identifier token.
REQ-010 tok_len  output  CNT_W+1  letters plus digits in the current token, saturating.
REQ-011 match_cnt  output  MATCH_W  number of 0->1 transitions of out since reset, wraps.

Function
REQ-012 Character classes: LETTER = 8'h41-8'h5A or 8'h61-8'h7A; DIGIT = 8'h30-8'h39; OTHER = everything else.
REQ-013 States: IDLE, ALPHA, DIGIT; registers alpha_cnt, digit_cnt (CNT_W each, saturate at 2^CNT_W-1, no wrap).
REQ-014 LETTER from any state -> ALPHA; from ALPHA alpha_cnt+1 (saturating); from IDLE or DIGIT alpha_cnt=1, digit_cnt=0.
REQ-015 DIGIT char from ALPHA -> DIGIT with digit_cnt=1; from DIGIT stays, digit_cnt+1 (saturating); from IDLE stays IDLE, counters 0.
REQ-016 OTHER from any state -> IDLE, alpha_cnt=0, digit_cnt=0.
REQ-017 char_vld=0: state, counters, out, tok_len, match_cnt all hold.
REQ-018 out is Moore, decoded from registered state only: 1 iff state=DIGIT and alpha_cnt>=MIN_ALPHA and digit_cnt>=MIN_DIGIT.
REQ-019 Latency: out reflects a character from the rising edge that consumes it; no combinational path from char or char_vld to any output.
REQ-020 tok_len = alpha_cnt + digit_cnt, computed at CNT_W+1 bits, combinational from registers.
REQ-021 match_cnt increments on the edge where next-state out=1 and current out=0; wraps from 2^MATCH_W-1 to 0.
REQ-022 Saturated counters still satisfy REQ-018 comparisons; token continues matching while saturated.
REQ-023 Letter after digits starts a new token; if that token later matches, match_cnt increments again.

Reset
REQ-024 rst_n=0 immediately forces state=IDLE, alpha_cnt=0, digit_cnt=0, match_cnt=0, so out=0, tok_len=0, regardless of clk.
REQ-025 Reset asserted mid-token discards the token; first consumed edge after rst_n deasserts follows REQ-014..016 from IDLE.

Configuration
REQ-026 Macro ID_UNDERSCORE_EN defined: char 8'h5F is classified LETTER (counts toward alpha_cnt, also allowed after digits as a new-token start).
REQ-027 Macro ID_UNDERSCORE_EN undefined: 8'h5F is classified OTHER and returns the FSM to IDLE.

Verification
REQ-028 Defaults, char_vld=1, stream "abcd1234 " one char per edge -> out 0 for a,b,c,d; 1 after '1','2','3','4'; 0 after ' '; tok_len after '4' = 8; match_cnt = 1.
REQ-029 MIN_ALPHA=2, MIN_DIGIT=3, stream "a123 ab12 ab123" -> out=1 only after final '3'; match_cnt=1.
REQ-030 Defaults, "a1b2" -> out 1 after '1', 0 after 'b', 1 after '2'; match_cnt=2; tok_len after '2' = 2.
REQ-031 Defaults, "x" then 20 digits -> digit_cnt saturates at 15, tok_len = 16, out stays 1, match_cnt=1.
REQ-032 "ab1" with char_vld=0 during '1' for 3 edges, then 1 -> out stays 0 while held, rises on the valid edge; rst_n pulsed low between edges mid "ab12" -> out, tok_len, match_cnt drop to 0 without a clock edge.
REQ-033 "_a1": with ID_UNDERSCORE_EN out=1 after '1', tok_len=3; without it out=1 after '1', tok_len=2.
